audio_out_fifo: RTL and testbench
=================================

Name: audio_out_fifo

Overview:
Sample buffer directly upstream of the I2S sender. Accepts 32-bit stereo sample words (16-bit L in [31:16], 16-bit R in [15:0]) from the monitor-link audio packet decoder and buffers them. Delivers one word per sender request tick as a single-cycle in_valid/data pulse. Manages stream start, priming, underrun and drain, and raises a DMA request toward the host when the fill level runs low.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 4
START_LEVEL, 8, fill level at which PRIME moves to RUN; 1..DEPTH
LOW_WATER, 4, dma_req asserted while level <= LOW_WATER in RUN; < DEPTH

Ports:
in_clk  in  1  single clock, shared with the sender's in_clk
rst_n  in  1  asynchronous active-low reset
wr_valid  in  1  decoder offers wr_data
wr_data  in  32  sample word
wr_ready  out  1  word accepted on the cycle when wr_valid && wr_ready
audio_start  in  1  1-cycle pulse: flush the FIFO and begin a stream
audio_end  in  1  1-cycle pulse: stop accepting words and drain
audio_req_tick  in  1  1-cycle pulse from the sender requesting the next sample
out_valid  out  1  1-cycle pulse; drives the sender's in_valid
out_data  out  32  sample word; drives the sender's data; valid with out_valid
dma_req  out  1  request more samples from the host
underrun  out  1  sticky flag: a tick arrived in RUN while the FIFO was empty
underrun_clr  in  1  clears underrun
level  out  $clog2(DEPTH)+1  current fill count
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE; pointers 0; level 0; wr_ready, out_valid, dma_req, underrun, busy = 0; out_data = 0.
- Storage: DEPTH x 32 RAM. Read/write pointers are $clog2(DEPTH)+1 bits and wrap naturally. full = level==DEPTH; empty = level==0.
- States:
  - IDLE: wr_ready=0. Ticks are ignored. audio_start -> PRIME.
  - PRIME: wr_ready=!full; dma_req=!full; ticks are ignored (no out_valid). level>=START_LEVEL -> RUN. audio_end -> DRAIN.
  - RUN: wr_ready=!full; dma_req=(level<=LOW_WATER). A tick while not empty pops the head; out_valid=1 and out_data=head on the next cycle. A tick while empty gives out_valid=1, out_data=0 (silence) on the next cycle and sets underrun. The state stays RUN. audio_end -> DRAIN.
  - DRAIN: wr_ready=0; dma_req=0. Ticks pop as in RUN. A tick while empty produces no pulse and does not set underrun. empty -> IDLE on the next cycle.
- audio_start in any state flushes the FIFO (level 0, pointers equal) and enters PRIME next cycle. Words offered that cycle are dropped. Any pending out_valid from a tick in the same cycle still issues.
- audio_start and audio_end in the same cycle: start wins.
- Latency: tick at cycle N -> out_valid at N+1, exactly one cycle wide. Back-to-back ticks yield back-to-back pulses.
- Simultaneous push and pop: both take effect and level is unchanged. When full, wr_ready=0 even if a pop occurs that cycle (wr_ready is based on the start-of-cycle level).
- A write is accepted only when wr_valid && wr_ready. Data order is strictly FIFO.
- underrun: set has priority over underrun_clr in the same cycle. A new audio_start does not clear it.
- dma_req and wr_ready are combinational from the state and the registered level. out_valid and out_data are registered.
- Reset asserted mid-stream: immediate return to reset values; no further out_valid.

Test Plan (DEPTH=8, START_LEVEL=4, LOW_WATER=2):
- Prime/run: audio_start, write 0x11110001..0x11110004 -> RUN after the 4th write. Four ticks -> four out_valid pulses one cycle after each tick, data in order. dma_req=1 at level<=2.
- Full: in RUN, write 8 words -> wr_ready=0 at level 8. 9th word is not accepted. Tick plus wr_valid in the same cycle -> word still refused; level 7 next cycle.
- Underrun: RUN with level 0; tick -> out_valid with out_data=0, underrun=1. underrun_clr together with a second empty tick -> underrun stays 1. underrun_clr alone -> 0.
- Drain: level 3, audio_end -> wr_ready=0. Three ticks deliver the remaining words. Next cycle IDLE with busy=0. A further tick -> no pulse.
- Restart: level 5 in RUN, audio_start coincident with a tick -> out_valid for the popped word, level 0, PRIME, dma_req=1.
- Async reset: assert rst_n=0 between clock edges mid-RUN -> all outputs 0 immediately. After release -> IDLE; ticks are ignored.

Source files
------------

// File: rtl/audio_out_fifo_if.sv
// rtl/audio_out_fifo_if.sv - decoder write channel and sender sample channel of the audio output buffer
interface audio_out_fifo_if;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        out_valid;
  logic [31:0] out_data;

  modport master (
    output wr_valid, wr_data,
    input  wr_ready, out_valid, out_data
  );

  modport slave (
    input  wr_valid, wr_data,
    output wr_ready, out_valid, out_data
  );
endinterface

// File: rtl/audio_out_fifo.sv
// rtl/audio_out_fifo.sv - stereo sample FIFO feeding the I2S sender with prime/run/drain control
module audio_out_fifo #(
  parameter int DEPTH       = 16,
  parameter int START_LEVEL = 8,
  parameter int LOW_WATER   = 4
) (
  input  logic                     in_clk,
  input  logic                     rst_n,
  audio_out_fifo_if.slave          bus,
  input  logic                     audio_start,
  input  logic                     audio_end,
  input  logic                     audio_req_tick,
  input  logic                     underrun_clr,
  output logic                     dma_req,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PRIME = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [LW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_data_q, out_data_d;
  logic          underrun_q, underrun_d;
  logic [31:0]   mem_q [DEPTH];

  logic full, empty, wr_ready_c, dma_req_c;
  logic push, pop, silence;

  always_comb begin
    full       = (level_q == LW'(DEPTH));
    empty      = (level_q == '0);
    wr_ready_c = 1'b0;
    dma_req_c  = 1'b0;
    case (state_q)
      PRIME: begin
        wr_ready_c = !full;
        dma_req_c  = !full;
      end
      RUN: begin
        wr_ready_c = !full;
        dma_req_c  = (level_q <= LW'(LOW_WATER));
      end
      default: ;
    endcase

    // A start flushes the FIFO, so a word offered in that cycle is dropped.
    push    = bus.wr_valid && wr_ready_c && !audio_start;
    pop     = audio_req_tick && !empty && (state_q == RUN || state_q == DRAIN);
    silence = audio_req_tick && empty && (state_q == RUN);

    state_d = state_q;
    if (audio_start) begin
      state_d = PRIME;
    end else begin
      case (state_q)
        PRIME: begin
          if (audio_end)                          state_d = DRAIN;
          else if (level_q >= LW'(START_LEVEL))   state_d = RUN;
        end
        RUN:     if (audio_end) state_d = DRAIN;
        DRAIN:   if (empty)     state_d = IDLE;
        default: ;
      endcase
    end

    wr_ptr_d = wr_ptr_q + LW'(push);
    rd_ptr_d = rd_ptr_q + LW'(pop);
    level_d  = level_q + LW'(push) - LW'(pop);
    if (audio_start) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end

    out_valid_d = pop || silence;
    out_data_d  = pop ? mem_q[rd_ptr_q[AW-1:0]] : 32'd0;

    // Setting wins over a same-cycle clear so no underrun event is lost.
    underrun_d = silence ? 1'b1 : (underrun_clr ? 1'b0 : underrun_q);
  end

  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      underrun_q  <= underrun_d;
    end
  end

  always_ff @(posedge in_clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.wr_data;
  end

  assign bus.wr_ready  = wr_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign dma_req       = dma_req_c;
  assign underrun      = underrun_q;
  assign level         = level_q;
  assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_audio_out_fifo.sv
// tb/tb_audio_out_fifo.sv - scoreboard bench for audio_out_fifo with DEPTH=8, START_LEVEL=4, LOW_WATER=2
module tb_audio_out_fifo;
  logic       in_clk;
  logic       rst_n;
  logic       audio_start, audio_end, audio_req_tick, underrun_clr;
  logic       dma_req, underrun, busy;
  logic [3:0] level;

  audio_out_fifo_if bus();

  audio_out_fifo #(.DEPTH(8), .START_LEVEL(4), .LOW_WATER(2)) dut (
    .in_clk         (in_clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .audio_start    (audio_start),
    .audio_end      (audio_end),
    .audio_req_tick (audio_req_tick),
    .underrun_clr   (underrun_clr),
    .dma_req        (dma_req),
    .underrun       (underrun),
    .level          (level),
    .busy           (busy)
  );

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc_cnt  = 0;
  int   pass_cnt = 0;
  int   tot_cnt  = 0;

  initial begin
    in_clk = 1'b0;
    forever #5 in_clk = ~in_clk;
  end

  always @(posedge in_clk) cyc_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every pulse must match the head of the scoreboard in data and cycle.
  always @(negedge in_clk) begin
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].cyc < cyc_cnt) begin
        tot_cnt++;
        $display("FAIL missed_pulse: no out_valid at cycle %0d, expected data 0x%08h", sb[0].cyc, sb[0].data);
        void'(sb.pop_front());
      end
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          tot_cnt++;
          $display("FAIL unexpected_pulse: out_valid with data 0x%08h at cycle %0d, expected none", bus.out_data, cyc_cnt);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_data", bus.out_data, e.data);
          chk("out_cycle", 32'(cyc_cnt), 32'(e.cyc));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic clk1();
    @(negedge in_clk);
  endtask

  task automatic write(input logic [31:0] d, input logic exp_rdy);
    chk("wr_ready", 32'(bus.wr_ready), 32'(exp_rdy));
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    clk1();
    bus.wr_valid = 1'b0;
  endtask

  task automatic tick(input logic exp_pulse, input logic [31:0] exp_data);
    if (exp_pulse) sb.push_back('{exp_data, cyc_cnt + 1});
    audio_req_tick = 1'b1;
    clk1();
    audio_req_tick = 1'b0;
  endtask

  task automatic pulse_start();
    audio_start = 1'b1;
    clk1();
    audio_start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    audio_start = 1'b0; audio_end = 1'b0; audio_req_tick = 1'b0; underrun_clr = 1'b0;
    bus.wr_valid = 1'b0; bus.wr_data = 32'd0;
    repeat (3) clk1();
    chk("rst_wr_ready", 32'(bus.wr_ready), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_dma_req", 32'(dma_req), 0);
    chk("rst_underrun", 32'(underrun), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_level", 32'(level), 0);
    rst_n = 1'b1;
    clk1();
    tick(1'b0, 0);
    chk("idle_wr_ready", 32'(bus.wr_ready), 0);

    // Prime and run
    pulse_start();
    chk("prime_busy", 32'(busy), 1);
    chk("prime_dma_req", 32'(dma_req), 1);
    tick(1'b0, 0);
    for (int i = 1; i <= 4; i++) write(32'h1111_0000 + 32'(i), 1'b1);
    chk("prime_level4", 32'(level), 4);
    chk("prime_still_dma", 32'(dma_req), 1);
    clk1();
    chk("run_dma_req_l4", 32'(dma_req), 0);
    tick(1'b1, 32'h1111_0001);
    chk("run_dma_req_l3", 32'(dma_req), 0);
    tick(1'b1, 32'h1111_0002);
    chk("run_dma_req_l2", 32'(dma_req), 1);
    tick(1'b1, 32'h1111_0003);
    tick(1'b1, 32'h1111_0004);
    chk("run_level0", 32'(level), 0);

    // Full
    for (int i = 0; i < 8; i++) write(32'h2222_0000 + 32'(i), 1'b1);
    chk("full_level", 32'(level), 8);
    write(32'h0000_0bad, 1'b0);
    chk("full_no_accept", 32'(level), 8);
    bus.wr_valid = 1'b1; bus.wr_data = 32'h0000_dead;
    chk("full_pop_wr_ready", 32'(bus.wr_ready), 0);
    tick(1'b1, 32'h2222_0000);
    bus.wr_valid = 1'b0;
    chk("full_pop_level", 32'(level), 7);
    for (int i = 1; i < 8; i++) tick(1'b1, 32'h2222_0000 + 32'(i));
    chk("full_drained", 32'(level), 0);

    // Underrun
    tick(1'b1, 32'h0);
    chk("underrun_set", 32'(underrun), 1);
    underrun_clr = 1'b1;
    tick(1'b1, 32'h0);
    underrun_clr = 1'b0;
    chk("underrun_set_wins", 32'(underrun), 1);
    underrun_clr = 1'b1;
    clk1();
    underrun_clr = 1'b0;
    chk("underrun_cleared", 32'(underrun), 0);

    // Drain
    for (int i = 1; i <= 3; i++) write(32'h3333_0000 + 32'(i), 1'b1);
    audio_end = 1'b1;
    clk1();
    audio_end = 1'b0;
    chk("drain_wr_ready", 32'(bus.wr_ready), 0);
    chk("drain_dma_req", 32'(dma_req), 0);
    chk("drain_busy", 32'(busy), 1);
    for (int i = 1; i <= 3; i++) tick(1'b1, 32'h3333_0000 + 32'(i));
    clk1();
    chk("drain_idle_busy", 32'(busy), 0);
    tick(1'b0, 0);
    chk("drain_no_underrun", 32'(underrun), 0);

    // Restart with a coincident tick
    pulse_start();
    for (int i = 1; i <= 5; i++) write(32'h4444_0000 + 32'(i), 1'b1);
    clk1();
    chk("restart_level5", 32'(level), 5);
    audio_start = 1'b1;
    tick(1'b1, 32'h4444_0001);
    audio_start = 1'b0;
    chk("restart_level0", 32'(level), 0);
    chk("restart_dma_req", 32'(dma_req), 1);
    chk("restart_busy", 32'(busy), 1);
    tick(1'b0, 0);

    // Asynchronous reset mid-run
    for (int i = 1; i <= 4; i++) write(32'h5555_0000 + 32'(i), 1'b1);
    clk1();
    chk("pre_reset_wr_ready", 32'(bus.wr_ready), 1);
    @(posedge in_clk);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_level", 32'(level), 0);
    chk("areset_busy", 32'(busy), 0);
    chk("areset_wr_ready", 32'(bus.wr_ready), 0);
    chk("areset_dma_req", 32'(dma_req), 0);
    chk("areset_out_valid", 32'(bus.out_valid), 0);
    chk("areset_out_data", bus.out_data, 0);
    repeat (2) clk1();
    rst_n = 1'b1;
    clk1();
    chk("post_reset_busy", 32'(busy), 0);
    tick(1'b0, 0);
    tick(1'b0, 0);
    chk("post_reset_level", 32'(level), 0);
    repeat (2) clk1();
    chk("scoreboard_empty", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
